// File: rtl/mvm_pkg.sv
// Shared types and helpers for the sparse matrix x spike-vector multiplier.
package mvm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CSR,
    ST_LOAD_SPIKE,
    ST_COMPUTE,
    ST_DRAIN
  } state_t;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Returns {overflow_flag, result} for an unsigned add limited to w bits (w <= 63).
  // With sat=1 the result clamps at 2^w-1 and the flag reports the clamp;
  // with sat=0 the result wraps and the flag stays low.
  function automatic logic [64:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w,
                                          input logic        sat);
    logic [63:0] sum;
    logic [63:0] lim;
    sum = a + b;
    lim = (64'd1 << w) - 64'd1;
    if (sum > lim) begin
      if (sat) return {1'b1, lim};
      return {1'b0, sum & lim};
    end
    return {1'b0, sum};
  endfunction

endpackage

// File: rtl/csr_entry_store.sv
// Matrix entry store: DEPTH x (row, col, val) registers.
// One synchronous write port, one combinational read port addressed by index.
module csr_entry_store #(
  parameter int DEPTH  = 16,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2,
  parameter int VAL_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [ROW_W-1:0]  i_wrow,
  input  logic [COL_W-1:0]  i_wcol,
  input  logic [VAL_W-1:0]  i_wval,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [ROW_W-1:0]  o_rrow,
  output logic [COL_W-1:0]  o_rcol,
  output logic [VAL_W-1:0]  o_rval
);

  logic [ROW_W-1:0] r_row [DEPTH];
  logic [COL_W-1:0] r_col [DEPTH];
  logic [VAL_W-1:0] r_val [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_row[i_waddr] <= i_wrow;
      r_col[i_waddr] <= i_wcol;
      r_val[i_waddr] <= i_wval;
    end
  end

  assign o_rrow = r_row[i_raddr];
  assign o_rcol = r_col[i_raddr];
  assign o_rval = r_val[i_raddr];

endmodule

// File: rtl/csr_spike_mvm_param.sv
// Sparse matrix x binary spike-vector multiplier: load entries, load spikes,
// accumulate one entry per cycle, then stream N_ROWS results with valid/ready.
module csr_spike_mvm_param
  import mvm_pkg::*;
#(
  parameter int N_ROWS   = 4,
  parameter int N_COLS   = 4,
  parameter int MAX_NNZ  = 16,
  parameter int VAL_W    = 8,
  parameter int ACC_W    = VAL_W + 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        reuse_matrix,
  output logic                        busy,
  input  logic                        entry_valid,
  output logic                        entry_ready,
  input  logic [idx_w(N_ROWS)-1:0]    entry_row,
  input  logic [idx_w(N_COLS)-1:0]    entry_col,
  input  logic [VAL_W-1:0]            entry_val,
  input  logic                        entry_last,
  input  logic                        spike_valid,
  output logic                        spike_ready,
  input  logic [N_COLS-1:0]           spike_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [idx_w(N_ROWS)-1:0]    out_row,
  output logic [ACC_W-1:0]            out_val,
  output logic                        out_last,
  output logic                        err
);

  localparam int ROW_W  = idx_w(N_ROWS);
  localparam int COL_W  = idx_w(N_COLS);
  localparam int ADDR_W = idx_w(MAX_NNZ);
  localparam int NNZ_W  = cnt_w(MAX_NNZ);

  state_t             r_state, w_state_nxt;
  logic [NNZ_W-1:0]   r_nnz, r_idx;
  logic               r_matrix_valid, r_err;
  logic [N_COLS-1:0]  r_spike;
  logic [ACC_W-1:0]   r_acc [N_ROWS];
  logic [ROW_W-1:0]   r_out_row;

  logic               w_entry_hs, w_entry_ok, w_has_room, w_store_we;
  logic               w_spike_hs, w_out_hs, w_out_last, w_compute_done, w_hit;
  logic               w_full_load, w_ovf;
  logic [ROW_W-1:0]   w_rd_row;
  logic [COL_W-1:0]   w_rd_col;
  logic [VAL_W-1:0]   w_rd_val;
  logic [64:0]        w_sat;

  assign busy        = (r_state != ST_IDLE);
  assign entry_ready = (r_state == ST_LOAD_CSR);
  assign spike_ready = (r_state == ST_LOAD_SPIKE);
  assign out_valid   = (r_state == ST_DRAIN);
  assign err         = r_err;

  assign w_entry_hs  = entry_valid && entry_ready;
  assign w_spike_hs  = spike_valid && spike_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_entry_ok  = (32'(entry_row) < N_ROWS) && (32'(entry_col) < N_COLS);
  assign w_has_room  = (r_nnz < NNZ_W'(MAX_NNZ));
  assign w_store_we  = w_entry_hs && w_entry_ok && w_has_room;
  assign w_full_load = !(reuse_matrix && r_matrix_valid);

  // An empty store still spends one compute cycle, so done is checked with idx+1.
  assign w_compute_done = ((r_idx + NNZ_W'(1)) >= r_nnz);

  csr_entry_store #(
    .DEPTH  (MAX_NNZ),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .VAL_W  (VAL_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_waddr (r_nnz[ADDR_W-1:0]),
    .i_wrow  (entry_row),
    .i_wcol  (entry_col),
    .i_wval  (entry_val),
    .i_raddr (r_idx[ADDR_W-1:0]),
    .o_rrow  (w_rd_row),
    .o_rcol  (w_rd_col),
    .o_rval  (w_rd_val)
  );

  assign w_hit = (r_idx < r_nnz) && r_spike[w_rd_col];
  assign w_sat = sat_add(64'(r_acc[w_rd_row]), 64'(w_rd_val), ACC_W, SATURATE);
  // Bits above ACC_W are zero by construction; folding them in keeps any carry visible.
  assign w_ovf = w_sat[64] || (|w_sat[63:ACC_W]);

  assign w_out_last = (r_out_row == ROW_W'(N_ROWS - 1));
  assign out_row    = r_out_row;
  assign out_val    = out_valid ? r_acc[r_out_row] : '0;
  assign out_last   = out_valid && w_out_last;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:       if (start) w_state_nxt = w_full_load ? ST_LOAD_CSR : ST_LOAD_SPIKE;
      ST_LOAD_CSR:   if (w_entry_hs && entry_last) w_state_nxt = ST_LOAD_SPIKE;
      ST_LOAD_SPIKE: if (w_spike_hs) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE:    if (w_compute_done) w_state_nxt = ST_DRAIN;
      ST_DRAIN:      if (w_out_hs && w_out_last) w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_nnz          <= '0;
      r_idx          <= '0;
      r_matrix_valid <= 1'b0;
      r_err          <= 1'b0;
      r_spike        <= '0;
      r_out_row      <= '0;
      for (int r = 0; r < N_ROWS; r++) r_acc[r] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            if (w_full_load) begin
              r_nnz          <= '0;
              r_matrix_valid <= 1'b0;
            end
          end
        end
        ST_LOAD_CSR: begin
          if (w_entry_hs) begin
            if (w_store_we) r_nnz <= r_nnz + NNZ_W'(1);
            else            r_err <= 1'b1;
            if (entry_last) r_matrix_valid <= 1'b1;
          end
        end
        ST_LOAD_SPIKE: begin
          if (w_spike_hs) begin
            r_spike <= spike_vec;
            r_idx   <= '0;
            for (int r = 0; r < N_ROWS; r++) r_acc[r] <= '0;
          end
        end
        ST_COMPUTE: begin
          r_idx <= r_idx + NNZ_W'(1);
          if (w_hit) begin
            r_acc[w_rd_row] <= w_sat[ACC_W-1:0];
            if (w_ovf) r_err <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) r_out_row <= w_out_last ? '0 : r_out_row + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_spike_mvm_param.sv
// Directed bench: two instances (saturating and wrapping) driven in lockstep.
module tb_csr_spike_mvm_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, reuse_matrix = 1'b0;
  logic       entry_valid = 1'b0, entry_last = 1'b0;
  logic [1:0] entry_row = '0, entry_col = '0;
  logic [7:0] entry_val = '0;
  logic       spike_valid = 1'b0;
  logic [3:0] spike_vec = '0;
  logic       out_ready = 1'b0;

  logic       busy, entry_ready, spike_ready, out_valid, out_last, err;
  logic [1:0] out_row;
  logic [9:0] out_val;
  logic       busy_b, entry_ready_b, spike_ready_b, out_valid_b, out_last_b, err_b;
  logic [1:0] out_row_b;
  logic [9:0] out_val_b;

  int n_cmp = 0;
  int n_bad = 0;
  int er_cnt = 0;
  int exp_a [4];
  int exp_b [4];

  always #5 clk = ~clk;

  always @(negedge clk) if (entry_ready) er_cnt <= er_cnt + 1;

  csr_spike_mvm_param #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_matrix(reuse_matrix), .busy(busy),
    .entry_valid(entry_valid), .entry_ready(entry_ready), .entry_row(entry_row),
    .entry_col(entry_col), .entry_val(entry_val), .entry_last(entry_last),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_vec(spike_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_val(out_val),
    .out_last(out_last), .err(err)
  );

  csr_spike_mvm_param #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_matrix(reuse_matrix), .busy(busy_b),
    .entry_valid(entry_valid), .entry_ready(entry_ready_b), .entry_row(entry_row),
    .entry_col(entry_col), .entry_val(entry_val), .entry_last(entry_last),
    .spike_valid(spike_valid), .spike_ready(spike_ready_b), .spike_vec(spike_vec),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_row(out_row_b), .out_val(out_val_b),
    .out_last(out_last_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic reuse);
    start = 1'b1;
    reuse_matrix = reuse;
    tick();
    start = 1'b0;
    reuse_matrix = 1'b0;
  endtask

  task automatic send_entry(input int row, input int col, input int val, input logic last);
    int n;
    entry_valid = 1'b1;
    entry_row = 2'(row);
    entry_col = 2'(col);
    entry_val = 8'(val);
    entry_last = last;
    n = 0;
    while (!entry_ready && n < 50) begin tick(); n++; end
    chk("entry_wait", 64'(n < 50), 1);
    tick();
    entry_valid = 1'b0;
    entry_last = 1'b0;
  endtask

  task automatic send_spikes(input logic [3:0] v);
    int n;
    spike_valid = 1'b1;
    spike_vec = v;
    n = 0;
    while (!spike_ready && n < 50) begin tick(); n++; end
    chk("spike_wait", 64'(n < 50), 1);
    tick();
    spike_valid = 1'b0;
  endtask

  // Collects four beats; on hold_row the consumer stalls for three cycles first.
  task automatic drain(input int hold_row);
    int n;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      chk("out_wait", 64'(n < 100), 1);
      chk($sformatf("row%0d_idx", r), 64'(out_row), 64'(r));
      chk($sformatf("row%0d_val_sat", r), 64'(out_val), 64'(exp_a[r]));
      chk($sformatf("row%0d_val_wrap", r), 64'(out_val_b), 64'(exp_b[r]));
      chk($sformatf("row%0d_last", r), 64'(out_last), 64'(r == 3));
      chk($sformatf("row%0d_valid_wrap", r), 64'(out_valid_b), 1);
      if (r == hold_row) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("hold_valid", 64'(out_valid), 1);
          chk("hold_row", 64'(out_row), 64'(r));
          chk("hold_val", 64'(out_val), 64'(exp_a[r]));
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("idle_after_drain", 64'(busy), 0);
  endtask

  initial begin
    int n;
    int er_snap;

    // Reset state (rst_n is active-high)
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_entry_ready", 64'(entry_ready), 0);
    chk("rst_spike_ready", 64'(spike_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_row", 64'(out_row), 0);
    chk("rst_out_val", 64'(out_val), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_err", 64'(err), 0);
    rst_n = 1'b0;
    tick();

    // Job 1: reuse requested with no valid matrix falls back to a full load
    start_job(1'b1);
    chk("j1_full_load", 64'(entry_ready), 1);
    send_entry(0, 0, 10, 1'b0);
    send_entry(1, 1, 20, 1'b0);
    send_entry(2, 2, 30, 1'b0);
    send_entry(3, 3, 40, 1'b1);
    chk("j1_in_load_spike", 64'(spike_ready), 1);
    // start and entry_valid while busy must be ignored
    start = 1'b1;
    entry_valid = 1'b1;
    tick();
    start = 1'b0;
    entry_valid = 1'b0;
    chk("busy_start_ignored", 64'(spike_ready), 1);
    chk("stray_entry_no_err", 64'(err), 0);
    send_spikes(4'b0101);
    // Four entries: out_valid appears nnz cycles after the handshake edge
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("j1_latency", 64'(n), 4);
    exp_a = '{10, 0, 30, 0};
    exp_b = '{10, 0, 30, 0};
    drain(-1);
    chk("j1_err", 64'(err), 0);

    // Job 2: matrix reuse, no entry load phase
    er_snap = er_cnt;
    start_job(1'b1);
    chk("j2_reuse", 64'(spike_ready), 1);
    send_spikes(4'b1010);
    exp_a = '{0, 20, 0, 40};
    exp_b = '{0, 20, 0, 40};
    drain(-1);
    chk("j2_no_entry_ready", 64'(er_cnt - er_snap), 0);

    // Job 3: backpressure on row 1
    start_job(1'b1);
    send_spikes(4'b1111);
    exp_a = '{10, 20, 30, 40};
    exp_b = '{10, 20, 30, 40};
    drain(1);

    // Job 4: overflow, clamped on u_sat and wrapped on u_wrap
    start_job(1'b0);
    for (int i = 0; i < 8; i++) send_entry(0, 0, 200, i == 7);
    send_spikes(4'b0001);
    exp_a = '{1023, 0, 0, 0};
    exp_b = '{576, 0, 0, 0};
    drain(-1);
    chk("j4_err_sat", 64'(err), 1);
    chk("j4_err_wrap", 64'(err_b), 0);

    // Job 5: 17th entry exceeds capacity and is dropped, but still ends the load
    start_job(1'b0);
    chk("j5_err_cleared", 64'(err), 0);
    for (int i = 0; i < 17; i++) send_entry(i % 4, (i / 4) % 4, 1, i == 16);
    chk("j5_in_load_spike", 64'(spike_ready), 1);
    chk("j5_err_sat", 64'(err), 1);
    chk("j5_err_wrap", 64'(err_b), 1);
    send_spikes(4'b1111);
    exp_a = '{4, 4, 4, 4};
    exp_b = '{4, 4, 4, 4};
    drain(-1);

    // Job 6: reset in the middle of a 16-cycle compute
    start_job(1'b1);
    send_spikes(4'b1111);
    for (int i = 0; i < 5; i++) tick();
    chk("j6_busy_mid", 64'(busy), 1);
    chk("j6_not_draining", 64'(out_valid), 0);
    rst_n = 1'b1;
    #1;
    chk("j6_rst_busy", 64'(busy), 0);
    chk("j6_rst_out_valid", 64'(out_valid), 0);
    chk("j6_rst_out_row", 64'(out_row), 0);
    chk("j6_rst_out_val", 64'(out_val), 0);
    chk("j6_rst_spike_ready", 64'(spike_ready), 0);
    tick();
    rst_n = 1'b0;
    tick();
    start_job(1'b1);
    chk("j6_reload_forced", 64'(entry_ready), 1);
    chk("j6_reload_forced_wrap", 64'(entry_ready_b), 1);
    chk("j6_no_spike_ready", 64'(spike_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
